ulpi_packetizer: RTL and testbench
==================================

Name: ulpi_packetizer

Overview:
- Sits between the ULPI receive interface (DATA/RXCMD/VALID byte stream, READY backpressure) and the FTDI usbstreamer byte sink (data/wr/have_space).
- Frames each USB bus packet into a record: fixed 7-byte header (magic, flags, length, timestamp), then the payload.
- Buffers one packet internally because the length is sent before the payload.
- Runs entirely in the CLK domain; the ULPI block already crosses data into DATA_CLK.

Parameters:
- MAX_LEN, 1024, maximum payload bytes stored per packet; must be a power of 2.
- LEN_W, 11, length counter width; must hold MAX_LEN.
- TS_W, 24, free-running timestamp width; fixed at 24 because the header carries 3 timestamp bytes.

Ports:
- CLK  in  1  system clock; same clock as ulpi DATA_CLK and the usbstreamer write side.
- RST_N  in  1  synchronous reset, active-low.
- IN_DATA  in  8  byte from ulpi DATA.
- IN_RXCMD  in  1  1 = IN_DATA is an RX CMD byte; 0 = packet data.
- IN_VALID  in  1  IN_DATA/IN_RXCMD valid this cycle.
- IN_READY  out  1  to ulpi READY; a byte is consumed when IN_VALID & IN_READY.
- OUT_DATA  out  8  byte to usbstreamer data.
- OUT_WR  out  1  write strobe to usbstreamer wr; one byte per asserted cycle.
- OUT_HAVE_SPACE  in  1  from usbstreamer have_space.
- OVERRUN  out  1  sticky; set when a packet arrives while IN_READY=0 semantics are violated, cleared only by reset.

Behaviour:
- Reset (RST_N=0 at a CLK edge) gives: state=IDLE, IN_READY=1, OUT_WR=0, OUT_DATA=0, OVERRUN=0, timestamp=0, buffer length=0, flags=0. Reset mid-capture or mid-emit discards the packet; no partial record is resumed.
- Timestamp: TS_W-bit counter, +1 every CLK, wraps 0xFFFFFF->0x000000.
- RX CMD decode: RxEvent = IN_DATA[5:4]. RxActive = IN_DATA[4]. RxError when RxEvent == 2'b11.
- IDLE:
  - IN_READY=1.
  - An accepted RXCMD with RxActive=1 latches timestamp, clears length and flags, and enters CAPTURE.
  - Data bytes accepted in IDLE are discarded.
- CAPTURE:
  - IN_READY=1.
  - Accepted data byte: written to buffer[len] and len+1 while len < MAX_LEN; otherwise dropped and flags[0] (TRUNC) set.
  - Accepted RXCMD with RxError: flags[1] (ERR) set.
  - Accepted RXCMD with RxActive=0: enters HDR next cycle. A zero-length packet is legal (LEN=0).
- HDR:
  - IN_READY=0.
  - Emits 7 bytes in order: 0xA0, FLAGS, {5'b0,len[10:8]}, len[7:0], ts[23:16], ts[15:8], ts[7:0].
  - After the 7th byte: enters PAYLOAD if len>0, else IDLE.
- PAYLOAD:
  - IN_READY=0.
  - Emits buffer[0..len-1] in order; IDLE after the last byte.
- Output handshake:
  - OUT_WR = emitting state & OUT_HAVE_SPACE (combinational gate on have_space).
  - OUT_DATA is valid in the same cycle as OUT_WR.
  - The byte pointer advances only on cycles with OUT_WR=1.
  - have_space low: OUT_WR=0, OUT_DATA held, no byte lost or duplicated.
- Buffer read is synchronous with 1-cycle latency. The implementation prefetches so that payload throughput is 1 byte/cycle while have_space=1. The HDR->PAYLOAD transition adds no bubble.
- OVERRUN: set if IN_VALID=1 with IN_RXCMD=1 and RxActive=1 arrives while IN_READY=0. The byte is still not consumed.
- Simultaneous events: an end-of-packet RXCMD and a reset in the same cycle resolves to reset. IN_VALID is ignored whenever IN_READY=0.

Optional Feature:
- Macro: ULPI_PKT_RXCMD_PASS_EN.
- Defined: an accepted RXCMD in IDLE that does not start a packet (RxActive=0) is emitted as a 2-byte event record, 0xA1 then the RXCMD byte.
  - Adds state EVT.
  - IN_READY=0 during EVT.
  - Same handshake rules as HDR.
- Undefined: such RXCMD bytes are discarded and state EVT does not exist.

Decomposition:
- Shared package ulpi_pkt_pkg holds:
  - Magic constants PKT_MAGIC=8'hA0 and EVT_MAGIC=8'hA1.
  - Flag bit indices FLAG_TRUNC=0 and FLAG_ERR=1.
  - HDR_LEN=7.
  - RxEvent encodings.
  - State enum.
- One sub-module: ulpi_pkt_buf, a simple dual-port RAM (MAX_LEN x 8) with a synchronous read port, inferred as block RAM.

Test Plan:
- Basic packet: RXCMD 0x10, data DE AD BE, RXCMD 0x00, captured with ts=0x000100, have_space=1 -> OUT stream A0 00 00 03 00 01 00 DE AD BE on 10 consecutive OUT_WR cycles; IN_READY=0 from HDR until the last byte.
- Backpressure: same packet with have_space=0 for 5 cycles after the 2nd payload byte -> OUT_WR=0 for those 5 cycles, OUT_DATA held at BE, total exactly 10 bytes, no duplicates.
- Overflow: MAX_LEN=16, 20 data bytes 0x00..0x13 -> header A0 01 00 10 ..., payload 0x00..0x0F only.
- Error and zero length: RXCMD 0x10, RXCMD 0x30, RXCMD 0x00 -> A0 02 00 00 ts×3, then IDLE with no payload.
- Reset mid-emit: RST_N=0 for 1 cycle after the 3rd header byte -> OUT_WR=0 on the following cycle, IN_READY=1. The next packet 0x55 emits a correct 8-byte record.
- Feature: RXCMD 0x0C in IDLE -> with ULPI_PKT_RXCMD_PASS_EN, OUT stream A1 0C; without it, no OUT_WR.

Source files
------------

// File: rtl/ulpi_pkt_pkg.sv
// rtl/ulpi_pkt_pkg.sv - shared constants, RX CMD decode helpers and FSM states for ulpi_packetizer (ULPI_PKT_RXCMD_PASS_EN adds ST_EVT)
package ulpi_pkt_pkg;

  localparam logic [7:0] PKT_MAGIC = 8'hA0;
  localparam logic [7:0] EVT_MAGIC = 8'hA1;

  localparam int FLAG_TRUNC = 0;
  localparam int FLAG_ERR   = 1;

  localparam int HDR_LEN = 7;

  // RxEvent field, RX CMD bits [5:4]
  localparam logic [1:0] RX_EV_SQUELCH   = 2'b00;
  localparam logic [1:0] RX_EV_ACTIVE    = 2'b01;
  localparam logic [1:0] RX_EV_HOST_DISC = 2'b10;
  localparam logic [1:0] RX_EV_ERROR     = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_HDR,
    ST_PAYLOAD
`ifdef ULPI_PKT_RXCMD_PASS_EN
    ,
    ST_EVT
`endif
  } state_t;

  function automatic logic rx_active(input logic [1:0] ev);
    return (ev == RX_EV_ACTIVE) || (ev == RX_EV_ERROR);
  endfunction

  function automatic logic rx_end(input logic [1:0] ev);
    return (ev == RX_EV_SQUELCH) || (ev == RX_EV_HOST_DISC);
  endfunction

  function automatic logic rx_error(input logic [1:0] ev);
    return ev == RX_EV_ERROR;
  endfunction

endpackage

// File: rtl/ulpi_pkt_buf.sv
// rtl/ulpi_pkt_buf.sv - simple dual-port packet buffer with registered read port
module ulpi_pkt_buf #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // write port: one byte per enabled cycle
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // read port: one cycle latency, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ulpi_packetizer.sv
// rtl/ulpi_packetizer.sv - frames ULPI RX packets into header+payload records (ULPI_PKT_RXCMD_PASS_EN forwards idle RX CMDs)
module ulpi_packetizer
  import ulpi_pkt_pkg::*;
#(
  parameter int MAX_LEN = 1024,
  parameter int LEN_W   = 11,
  parameter int TS_W    = 24
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] IN_DATA,
  input  logic       IN_RXCMD,
  input  logic       IN_VALID,
  output logic       IN_READY,
  output logic [7:0] OUT_DATA,
  output logic       OUT_WR,
  input  logic       OUT_HAVE_SPACE,
  output logic       OVERRUN
);

  localparam int AW = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t state, state_nxt;

  logic [TS_W-1:0]  ts;
  logic [TS_W-1:0]  ts_lat;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] rd_ptr;
  logic [LEN_W-1:0] rd_ptr_inc;
  logic [1:0]       flags;
  logic [2:0]       hdr_idx;
  logic [15:0]      len_ext;

  logic accept, is_start, is_end, is_err, is_data, last_hdr, last_pay;
  logic          buf_we;
  logic [AW-1:0] buf_raddr;
  logic [7:0]    buf_rdata;

`ifdef ULPI_PKT_RXCMD_PASS_EN
  logic [7:0] evt_byte;
  logic       is_evt;
  assign is_evt = accept & IN_RXCMD & ~rx_active(IN_DATA[5:4]);
`endif

  assign accept     = IN_VALID & IN_READY;
  assign is_start   = accept & IN_RXCMD & rx_active(IN_DATA[5:4]);
  assign is_end     = accept & IN_RXCMD & rx_end(IN_DATA[5:4]);
  assign is_err     = accept & IN_RXCMD & rx_error(IN_DATA[5:4]);
  assign is_data    = accept & ~IN_RXCMD;
  assign last_hdr   = hdr_idx == 3'(HDR_LEN - 1);
  assign rd_ptr_inc = rd_ptr + LEN_W'(1);
  assign last_pay   = rd_ptr_inc == len;
  assign len_ext    = 16'(len);
  assign buf_we     = (state == ST_CAPTURE) & is_data & (len < MAX_LEN_L);

  ulpi_pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (CLK),
    .we    (buf_we),
    .waddr (len[AW-1:0]),
    .wdata (IN_DATA),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  // state register
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (is_start) state_nxt = ST_CAPTURE;
`ifdef ULPI_PKT_RXCMD_PASS_EN
        else if (is_evt) state_nxt = ST_EVT;
`endif
      end
      ST_CAPTURE: if (is_end) state_nxt = ST_HDR;
      ST_HDR: begin
        if (OUT_WR && last_hdr) state_nxt = (len != '0) ? ST_PAYLOAD : ST_IDLE;
      end
      ST_PAYLOAD: if (OUT_WR && last_pay) state_nxt = ST_IDLE;
`ifdef ULPI_PKT_RXCMD_PASS_EN
      ST_EVT: if (OUT_WR && hdr_idx == 3'd1) state_nxt = ST_IDLE;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // outputs: ready/write gating, output byte mux, buffer read address with prefetch
  always_comb begin
    IN_READY  = 1'b0;
    OUT_WR    = 1'b0;
    OUT_DATA  = 8'h00;
    buf_raddr = '0;
    case (state)
      ST_IDLE, ST_CAPTURE: IN_READY = 1'b1;
      ST_HDR: begin
        OUT_WR = OUT_HAVE_SPACE;
        case (hdr_idx)
          3'd0:    OUT_DATA = PKT_MAGIC;
          3'd1:    OUT_DATA = {6'b0, flags};
          3'd2:    OUT_DATA = len_ext[15:8];
          3'd3:    OUT_DATA = len_ext[7:0];
          3'd4:    OUT_DATA = ts_lat[23:16];
          3'd5:    OUT_DATA = ts_lat[15:8];
          default: OUT_DATA = ts_lat[7:0];
        endcase
      end
      ST_PAYLOAD: begin
        OUT_WR    = OUT_HAVE_SPACE;
        OUT_DATA  = buf_rdata;
        // fetch the next byte only when the current one leaves, so rdata tracks rd_ptr
        buf_raddr = OUT_HAVE_SPACE ? rd_ptr_inc[AW-1:0] : rd_ptr[AW-1:0];
      end
`ifdef ULPI_PKT_RXCMD_PASS_EN
      ST_EVT: begin
        OUT_WR   = OUT_HAVE_SPACE;
        OUT_DATA = (hdr_idx == 3'd0) ? EVT_MAGIC : evt_byte;
      end
`endif
      default: ;
    endcase
  end

  // datapath: timestamp, capture bookkeeping, emit pointers, sticky overrun
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ts      <= '0;
      ts_lat  <= '0;
      len     <= '0;
      rd_ptr  <= '0;
      flags   <= '0;
      hdr_idx <= '0;
      OVERRUN <= 1'b0;
`ifdef ULPI_PKT_RXCMD_PASS_EN
      evt_byte <= '0;
`endif
    end else begin
      ts <= ts + TS_W'(1);
      if (IN_VALID && !IN_READY && IN_RXCMD && rx_active(IN_DATA[5:4])) OVERRUN <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (is_start) begin
            ts_lat  <= ts;
            len     <= '0;
            flags   <= '0;
            rd_ptr  <= '0;
            hdr_idx <= '0;
          end
`ifdef ULPI_PKT_RXCMD_PASS_EN
          else if (is_evt) begin
            evt_byte <= IN_DATA;
            hdr_idx  <= '0;
          end
`endif
        end
        ST_CAPTURE: begin
          if (is_data) begin
            if (len < MAX_LEN_L) len <= len + LEN_W'(1);
            else                 flags[FLAG_TRUNC] <= 1'b1;
          end
          if (is_err) flags[FLAG_ERR] <= 1'b1;
        end
        ST_HDR: if (OUT_WR) hdr_idx <= last_hdr ? 3'd0 : hdr_idx + 3'd1;
        ST_PAYLOAD: if (OUT_WR) rd_ptr <= rd_ptr_inc;
`ifdef ULPI_PKT_RXCMD_PASS_EN
        ST_EVT: if (OUT_WR) hdr_idx <= hdr_idx + 3'd1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_packetizer.sv
// tb/tb_ulpi_packetizer.sv - table-driven bench for ulpi_packetizer
module tb_ulpi_packetizer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_rxcmd;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_wr;
  logic       have_space;
  logic       overrun;

  always #5 clk = ~clk;

  ulpi_packetizer #(.MAX_LEN(16), .LEN_W(11), .TS_W(24)) dut (
    .CLK            (clk),
    .RST_N          (rst_n),
    .IN_DATA        (in_data),
    .IN_RXCMD       (in_rxcmd),
    .IN_VALID       (in_valid),
    .IN_READY       (in_ready),
    .OUT_DATA       (out_data),
    .OUT_WR         (out_wr),
    .OUT_HAVE_SPACE (have_space),
    .OVERRUN        (overrun)
  );

  // reference timestamp and cycle counter
  logic [23:0] ts_model;
  int cyc = 0;
  always @(posedge clk) begin
    if (!rst_n) ts_model <= 24'h0;
    else        ts_model <= ts_model + 24'h1;
    cyc <= cyc + 1;
  end

  // collect every written output byte
  logic [7:0] got[$];
  int         got_cyc[$];
  always @(negedge clk) begin
    if (out_wr === 1'b1) begin
      got.push_back(out_data);
      got_cyc.push_back(cyc);
    end
  end

  int checks = 0;
  int failures = 0;
  logic [7:0]  exp_q[$];
  logic [23:0] start_ts;
  logic        in_pkt;

  typedef struct {
    logic [8:0] seq [8];
    int         n;
    logic [7:0] flags;
    int         len;
    logic [7:0] pay [8];
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic rx, input logic [7:0] d);
    if (rx && d[4] && !in_pkt) begin
      start_ts = ts_model;
      in_pkt = 1'b1;
    end else if (rx && !d[4]) begin
      in_pkt = 1'b0;
    end
    in_valid = 1'b1;
    in_rxcmd = rx;
    in_data  = d;
    tick(1);
    in_valid = 1'b0;
    in_rxcmd = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic build_hdr(input logic [7:0] flags, input int len);
    logic [15:0] l;
    l = 16'(len);
    exp_q.delete();
    exp_q.push_back(8'hA0);
    exp_q.push_back(flags);
    exp_q.push_back(l[15:8]);
    exp_q.push_back(l[7:0]);
    exp_q.push_back(start_ts[23:16]);
    exp_q.push_back(start_ts[15:8]);
    exp_q.push_back(start_ts[7:0]);
  endtask

  task automatic wait_got(input int n);
    int k;
    k = 0;
    while (got.size() < n && k < 300) begin
      tick(1);
      k++;
    end
  endtask

  task automatic compare_stream(input string name, input logic chk_span);
    wait_got(exp_q.size());
    tick(4);
    check({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) check($sformatf("%s_byte%0d", name, i), {24'h0, got[i]}, {24'h0, exp_q[i]});
      else                check($sformatf("%s_byte%0d", name, i), 32'hFFFF_FFFF, {24'h0, exp_q[i]});
    end
    if (chk_span && got.size() > 0)
      check({name, "_span"}, got_cyc[got.size()-1] - got_cyc[0], exp_q.size() - 1);
    check({name, "_ready_after"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    rst_n = 1'b0; in_valid = 1'b0; in_rxcmd = 1'b0; in_data = 8'h00;
    have_space = 1'b1; in_pkt = 1'b0; start_ts = 24'h0;

    vecs[0].seq = '{9'h110, 9'h0DE, 9'h0AD, 9'h0BE, 9'h100, 9'h0, 9'h0, 9'h0};
    vecs[0].n = 5; vecs[0].flags = 8'h00; vecs[0].len = 3;
    vecs[0].pay = '{8'hDE, 8'hAD, 8'hBE, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    vecs[1].seq = '{9'h110, 9'h130, 9'h100, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0};
    vecs[1].n = 3; vecs[1].flags = 8'h02; vecs[1].len = 0;
    vecs[1].pay = '{8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    vecs[2].seq = '{9'h055, 9'h110, 9'h011, 9'h022, 9'h120, 9'h0, 9'h0, 9'h0};
    vecs[2].n = 5; vecs[2].flags = 8'h00; vecs[2].len = 2;
    vecs[2].pay = '{8'h11, 8'h22, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    vecs[3].seq = '{9'h110, 9'h001, 9'h130, 9'h002, 9'h100, 9'h0, 9'h0, 9'h0};
    vecs[3].n = 5; vecs[3].flags = 8'h02; vecs[3].len = 2;
    vecs[3].pay = '{8'h01, 8'h02, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};

    tick(2);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_wr", out_wr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;

    // line the first packet up with timestamp 0x000100
    k = 0;
    while (ts_model != 24'h000100 && k < 1000) begin
      tick(1);
      k++;
    end

    for (int i = 0; i < 4; i++) begin
      got.delete(); got_cyc.delete();
      for (int j = 0; j < vecs[i].n; j++) send(vecs[i].seq[j][8], vecs[i].seq[j][7:0]);
      check($sformatf("v%0d_ready_busy", i), in_ready, 0);
      build_hdr(vecs[i].flags, vecs[i].len);
      for (int j = 0; j < vecs[i].len; j++) exp_q.push_back(vecs[i].pay[j]);
      compare_stream($sformatf("v%0d", i), 1'b1);
    end

    // backpressure: have_space low for 5 cycles after the 2nd payload byte
    got.delete(); got_cyc.delete();
    send(1, 8'h10); send(0, 8'hDE); send(0, 8'hAD); send(0, 8'hBE); send(1, 8'h00);
    wait_got(9);
    have_space = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #2;
      check($sformatf("bp_wr_low%0d", c), out_wr, 0);
      check($sformatf("bp_hold%0d", c), out_data, 8'hBE);
      tick(1);
    end
    have_space = 1'b1;
    build_hdr(8'h00, 3);
    exp_q.push_back(8'hDE); exp_q.push_back(8'hAD); exp_q.push_back(8'hBE);
    compare_stream("bp", 1'b0);

    // overflow: 20 bytes into a 16-byte buffer
    got.delete(); got_cyc.delete();
    send(1, 8'h10);
    for (int b = 0; b < 20; b++) send(0, 8'(b));
    send(1, 8'h00);
    build_hdr(8'h01, 16);
    for (int b = 0; b < 16; b++) exp_q.push_back(8'(b));
    compare_stream("ovf", 1'b1);

    // overrun: packet start offered while busy is flagged and not consumed
    got.delete(); got_cyc.delete();
    send(1, 8'h10); send(0, 8'h01); send(1, 8'h00);
    in_valid = 1'b1; in_rxcmd = 1'b1; in_data = 8'h10;
    tick(1);
    in_valid = 1'b0; in_rxcmd = 1'b0; in_data = 8'h00;
    check("ovr_set", overrun, 1);
    build_hdr(8'h00, 1);
    exp_q.push_back(8'h01);
    compare_stream("ovr", 1'b1);

    // RX CMD without RxActive while idle
    got.delete(); got_cyc.delete();
    send(1, 8'h0C);
    exp_q.delete();
`ifdef ULPI_PKT_RXCMD_PASS_EN
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'h0C);
`endif
    compare_stream("evt", 1'b1);
    check("ovr_sticky", overrun, 1);

    // reset after the 3rd header byte
    got.delete(); got_cyc.delete();
    send(1, 8'h10); send(0, 8'h01); send(0, 8'h02); send(1, 8'h00);
    wait_got(3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    in_pkt = 1'b0;
    check("mid_rst_out_wr", out_wr, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_overrun", overrun, 0);
    tick(2);
    got.delete(); got_cyc.delete();
    send(1, 8'h10); send(0, 8'h55); send(1, 8'h00);
    build_hdr(8'h00, 1);
    exp_q.push_back(8'h55);
    compare_stream("post_rst", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
